// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and datapath control bundle
// master drives the datapath controls; slave is the datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       memReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       PCSource;
  logic       illegalOp;
  logic [3:0] stateOut;

  modport master (
    input  opcode, memReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, illegalOp, stateOut
  );

  modport slave (
    output opcode, memReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, illegalOp, stateOut
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS subset main control FSM
// Fetch/decode/execute/memory/writeback sequencing with memory-ready stalls.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ANDI  = 6'b001100
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ANDIEX  = 4'd9,
    S_ANDIWB  = 4'd10
  } state_t;

  typedef struct packed {
    logic       fetch_strobe;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       pcsource;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   op_legal;
  logic   live;

  // Moore control word for a state; unreachable codes decode to all zeros.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread      = 1'b1;
        c.alusrcb      = 2'b01;
        c.fetch_strobe = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 1'b1;
      end
      S_ANDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = 2'b11;
      end
      S_ANDIWB: begin
        c.regwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
               (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
               (bus.opcode == OP_ANDI);
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_next = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                state_next = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  state_next = S_BRANCH;
        else if (bus.opcode == OP_ANDI)                 state_next = S_ANDIEX;
        else                                            state_next = S_FETCH;
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_next = S_MEMRD;
        else if (bus.opcode == OP_SW) state_next = S_MEMWR;
        else                          state_next = S_FETCH;
      end
      S_MEMRD:   state_next = bus.memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = bus.memReady ? S_FETCH : S_MEMWR;
      S_EXEC:    state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ANDIEX:  state_next = S_ANDIWB;
      S_ANDIWB:  state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= decode(S_FETCH);
    end else begin
      state  <= state_next;
      ctrl_q <= decode(state_next);
    end
  end

  // Reset masks every output so nothing leaks out while it is held.
  assign live = ~reset;

  assign bus.PCWrite     = live & ctrl_q.fetch_strobe & bus.memReady;
  assign bus.IRWrite     = live & ctrl_q.fetch_strobe & bus.memReady;
  assign bus.PCWriteCond = live & ctrl_q.pcwritecond;
  assign bus.IorD        = live & ctrl_q.iord;
  assign bus.MemRead     = live & ctrl_q.memread;
  assign bus.MemWrite    = live & ctrl_q.memwrite;
  assign bus.RegDst      = live & ctrl_q.regdst;
  assign bus.MemtoReg    = live & ctrl_q.memtoreg;
  assign bus.RegWrite    = live & ctrl_q.regwrite;
  assign bus.ALUSrcA     = live & ctrl_q.alusrca;
  assign bus.ALUSrcB     = ctrl_q.alusrcb & {2{live}};
  assign bus.ALUOp       = ctrl_q.aluop & {2{live}};
  assign bus.PCSource    = live & ctrl_q.pcsource;
  assign bus.illegalOp   = live & (state == S_DECODE) & ~op_legal;
  assign bus.stateOut    = state & {4{live}};

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
// Stimulus pushes the expected output word per cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    logic [19:0] v;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  multicycle_control_if ifc ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stateOut, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp}
  function automatic logic [19:0] observed();
    return {ifc.stateOut, ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead,
            ifc.MemWrite, ifc.IRWrite, ifc.RegDst, ifc.MemtoReg, ifc.RegWrite,
            ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.illegalOp};
  endfunction

  function automatic logic [19:0] expv(input int st, input logic mr, input logic ill);
    logic [3:0] s4;
    logic pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, sa, ps, il;
    logic [1:0] sb_sel, aop;
    s4 = st[3:0];
    {pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, sa, ps, il} = '0;
    sb_sel = 2'b00;
    aop    = 2'b00;
    case (st)
      0:  begin mrd = 1; sb_sel = 2'b01; pw = mr; irw = mr; end
      1:  begin sb_sel = 2'b11; il = ill; end
      2:  begin sa = 1; sb_sel = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 1; end
      9:  begin sa = 1; sb_sel = 2'b10; aop = 2'b11; end
      10: begin rw = 1; end
      default: s4 = 4'd0;
    endcase
    return {s4, pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, sa, sb_sel, aop, ps, il};
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input int st, input logic ill, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = r;
    ifc.opcode   = op;
    ifc.memReady = mr;
    e.v    = r ? 20'h0 : expv(st, mr, ill);
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [19:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = observed();
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s: got %05h expected %05h", e.name, got, e.v);
        end
      end
    end
  end

  initial begin : stimulus
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    ifc.opcode   = LW;
    ifc.memReady = 1'b1;

    for (int i = 0; i < 3; i++) step(1, LW, 1, 0, 0, "reset_hold");

    step(0, LW, 1, 0, 0, "lw_fetch");
    step(0, LW, 1, 1, 0, "lw_decode");
    step(0, LW, 1, 2, 0, "lw_memadr");
    step(0, LW, 1, 3, 0, "lw_memrd");
    step(0, LW, 1, 4, 0, "lw_memwb");

    step(0, RT, 1, 0, 0, "rt_fetch");
    step(0, RT, 1, 1, 0, "rt_decode");
    step(0, RT, 1, 6, 0, "rt_exec");
    step(0, RT, 1, 7, 0, "rt_wb");

    step(0, SW, 1, 0, 0, "sw_fetch");
    step(0, SW, 1, 1, 0, "sw_decode");
    step(0, SW, 1, 2, 0, "sw_memadr");
    for (int i = 0; i < 3; i++) step(0, SW, 0, 5, 0, "sw_memwr_stall");
    step(0, SW, 1, 5, 0, "sw_memwr_done");

    step(0, BEQ, 1, 0, 0, "beq_fetch");
    step(0, BEQ, 1, 1, 0, "beq_decode");
    step(0, BEQ, 1, 8, 0, "beq_branch");
    step(0, ANDI, 1, 0, 0, "andi_fetch");
    step(0, ANDI, 1, 1, 0, "andi_decode");
    step(0, ANDI, 1, 9, 0, "andi_ex");
    step(0, ANDI, 1, 10, 0, "andi_wb");

    for (int i = 0; i < 5; i++) step(0, RT, 0, 0, 0, "fetch_stall");
    step(0, RT, 1, 0, 0, "fetch_ready");
    step(0, RT, 1, 1, 0, "stall_rt_decode");
    step(0, RT, 1, 6, 0, "stall_rt_exec");
    step(0, RT, 1, 7, 0, "stall_rt_wb");

    step(0, BAD, 1, 0, 0, "ill_fetch");
    step(0, BAD, 1, 1, 1, "ill_decode");
    step(0, LW, 1, 0, 0, "ill_back_fetch");
    step(0, LW, 1, 1, 0, "ar_decode");
    step(0, LW, 1, 2, 0, "ar_memadr");
    step(0, LW, 0, 3, 0, "ar_memrd");

    // Assert reset between clock edges while in MEMRD.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.stateOut !== 4'd0 || ifc.RegWrite !== 1'b0 || ifc.MemRead !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: stateOut=%0d RegWrite=%0b MemRead=%0b required 0 0 0",
               ifc.stateOut, ifc.RegWrite, ifc.MemRead);
    end

    step(1, LW, 1, 0, 0, "ar_hold");
    step(0, LW, 0, 0, 0, "ar_release_fetch");
    step(0, LW, 0, 0, 0, "ar_no_regwrite");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expectations, required 0", sb.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS subset datapath.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback phases.
- Drives the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 subtract, 10 R-type funct, 11 and), plus every datapath mux select and write strobe.
- Stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ANDI, 6'b001100, and-immediate opcode

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from instruction register
- memReady  input  1  memory completes current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero
- IorD  output  1  memory address select: 0 PC, 1 ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register: 0 rt, 1 rd
- MemtoReg  output  1  writeback data: 0 ALUOut, 1 MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 PC, 1 register A
- ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  output  2  to ALU control decoder
- PCSource  output  1  0 ALU result, 1 ALUOut
- illegalOp  output  1  one-cycle pulse on unsupported opcode
- stateOut  output  4  current state code, for debug

Behaviour:
- State register 4 bits. Async reset forces FETCH. While reset is high, every output is 0, including stateOut.
- Outputs are Moore-decoded from state. Only the gated strobes below also depend on memReady. Unlisted outputs are 0.
- FETCH (0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=memReady, PCSource=0.
  - Stays in FETCH while memReady=0. Goes to DECODE when memReady=1.
- DECODE (1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: LW/SW→MEMADR; RTYPE→EXEC; BEQ→BRANCH; ANDI→ANDIEX.
  - Any other opcode → FETCH with illegalOp=1 for this cycle only. No register or memory write occurs.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD (3): MemRead=1, IorD=1. Holds until memReady, then goes to MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Holds until memReady, then goes to FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPEWB.
- RTYPEWB (7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Goes to FETCH.
- ANDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to ANDIWB.
- ANDIWB (10): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Codes 11–15 are unreachable. If entered, go to FETCH next cycle with all outputs 0.
- Latency with memReady tied high:
  - LW 5 cycles; SW 4; R-type 4; ANDI 4; BEQ 3; illegal 2.
  - Each memReady-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- memReady is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: state returns to FETCH immediately, asynchronously. No partial RegWrite or MemWrite is issued after the reset edge.

Test Plan:
- Reset held 3 cycles, memReady=1, opcode=6'b100011 → all outputs 0 during reset. After release, stateOut sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- opcode=6'b000000, memReady=1 → states 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 in state 7.
- opcode=6'b101011, memReady low for 3 cycles in MEMWR → state 5 held 4 cycles with MemWrite=1, IorD=1 throughout, then FETCH. RegWrite never 1.
- opcode=6'b000100 then 6'b001100 back-to-back → BEQ shows ALUOp=01 and PCWriteCond=1 in state 8. ANDI shows ALUOp=11 and ALUSrcB=10 in state 9, RegWrite in state 10.
- memReady=0 for 5 cycles in FETCH → IRWrite=PCWrite=0 for those cycles, MemRead=1. A single-cycle IRWrite/PCWrite pulse occurs when memReady rises.
- opcode=6'b111111 → illegalOp=1 for exactly the DECODE cycle, then FETCH. Separately, reset asserted asynchronously in state 3 (LW) → stateOut=0 without waiting for a clock edge, and no RegWrite follows.
